// File: rtl/uart_wide_mem_loader_if.sv
// Write port from the UART loader into the wide SPM (req/gnt, 512-bit data).
interface uart_wide_mem_loader_if #(
  parameter int unsigned AddrWidth = 14
) ();
  logic                 req;
  logic [AddrWidth-1:0] addr;
  logic [511:0]         wdata;
  logic                 gnt;

  modport master (output req, addr, wdata, input gnt);
  modport slave  (input req, addr, wdata, output gnt);
endinterface

// File: rtl/uart_wide_mem_loader.sv
// UART boot loader: 8N1 bytes -> 0xA5 sync, 32-bit word count, 512-bit words written to the wide SPM.
//
// rx FSM    | meaning
// RX_IDLE   | line idle, waiting for a falling edge
// RX_START  | half-bit wait, confirm start bit is still low
// RX_DATA   | sampling 8 data bits, LSB first
// RX_STOP   | sampling stop bit
//
// loader FSM | meaning
// LD_SYNC    | waiting for 0xA5
// LD_LEN     | collecting 4-byte little-endian word count
// LD_DATA    | packing bytes into words and writing them
// LD_DONE    | image fully written (sticky)
// LD_ERR     | error latched (sticky)
module uart_wide_mem_loader #(
  parameter int unsigned ClkFreq   = 1_000_000_000,
  parameter int unsigned Baud      = 20_000_000,
  parameter int unsigned MemDepth  = 16384,
  parameter int unsigned AddrWidth = $clog2(MemDepth)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  uart_wide_mem_loader_if.master        mem,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [1:0]                    err_code_o
);

  localparam int unsigned Div  = ClkFreq / Baud;
  localparam int unsigned CntW = $clog2(Div) + 1;
  localparam logic [CntW-1:0]    DivLoad  = CntW'(Div - 1);
  localparam logic [CntW-1:0]    HalfLoad = CntW'(Div / 2 - 1);
  localparam logic [AddrWidth:0] WordOne  = 1;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {LD_SYNC, LD_LEN, LD_DATA, LD_DONE, LD_ERR} ld_state_e;

  logic rx_q1, rx_q2, rx_prev;
  logic rx_s;

  rx_state_e       rx_state, rx_state_nxt;
  logic [CntW-1:0] rx_cnt, rx_cnt_nxt;
  logic [2:0]      bit_idx, bit_idx_nxt;
  logic [7:0]      rx_shift, rx_shift_nxt;
  logic            byte_valid, frame_err;

  ld_state_e          ld_state, ld_state_nxt;
  logic [1:0]         err_code_q, err_code_nxt;
  logic [31:0]        len_q, len_full;
  logic [1:0]         len_idx;
  logic [5:0]         byte_idx;
  logic [511:0]       asm_q, asm_nxt;
  logic               wr_req;
  logic [AddrWidth-1:0] wr_addr;
  logic [511:0]       wr_data;
  logic [AddrWidth:0] n_words, words_rcvd, grants_q;
  logic               gnt_fire, word_done, overrun, last_grant;

  assign rx_s = rx_q2;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_q1   <= 1'b1;
      rx_q2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_q1   <= rx_i;
      rx_q2   <= rx_q1;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      bit_idx  <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      rx_cnt   <= rx_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      rx_shift <= rx_shift_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    bit_idx_nxt  = bit_idx;
    rx_shift_nxt = rx_shift;
    byte_valid   = 1'b0;
    frame_err    = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_state_nxt = RX_START;
          rx_cnt_nxt   = HalfLoad;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          if (!rx_s) begin
            rx_state_nxt = RX_DATA;
            rx_cnt_nxt   = DivLoad;
            bit_idx_nxt  = '0;
          end else begin
            rx_state_nxt = RX_IDLE;
          end
        end else begin
          rx_cnt_nxt = rx_cnt - CntW'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_nxt = {rx_s, rx_shift[7:1]};
          rx_cnt_nxt   = DivLoad;
          if (bit_idx == 3'd7) rx_state_nxt = RX_STOP;
          else                 bit_idx_nxt  = bit_idx + 3'd1;
        end else begin
          rx_cnt_nxt = rx_cnt - CntW'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          if (rx_s) byte_valid = 1'b1;
          else      frame_err  = 1'b1;
          rx_state_nxt = RX_IDLE;
        end else begin
          rx_cnt_nxt = rx_cnt - CntW'(1);
        end
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  // Count bytes shift in from the top so the first byte ends up in [7:0].
  assign len_full   = {rx_shift, len_q[31:8]};
  assign gnt_fire   = wr_req && mem.gnt;
  assign word_done  = (ld_state == LD_DATA) && byte_valid && (byte_idx == 6'd63) &&
                      (words_rcvd != n_words);
  assign overrun    = word_done && wr_req && !mem.gnt;
  assign last_grant = gnt_fire && ((grants_q + WordOne) == n_words);

  always_comb begin
    asm_nxt = asm_q;
    asm_nxt[{byte_idx, 3'b000} +: 8] = rx_shift;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ld_state   <= LD_SYNC;
      err_code_q <= 2'd0;
    end else begin
      ld_state   <= ld_state_nxt;
      err_code_q <= err_code_nxt;
    end
  end

  always_comb begin
    ld_state_nxt = ld_state;
    err_code_nxt = err_code_q;
    unique case (ld_state)
      LD_SYNC: begin
        if (byte_valid && rx_shift == 8'hA5) ld_state_nxt = LD_LEN;
      end
      LD_LEN: begin
        if (frame_err) begin
          ld_state_nxt = LD_ERR;
          err_code_nxt = 2'd1;
        end else if (byte_valid && len_idx == 2'd3) begin
          if (len_full == 32'd0) begin
            ld_state_nxt = LD_DONE;
          end else if (len_full > MemDepth) begin
            ld_state_nxt = LD_ERR;
            err_code_nxt = 2'd3;
          end else begin
            ld_state_nxt = LD_DATA;
          end
        end
      end
      LD_DATA: begin
        if (frame_err) begin
          ld_state_nxt = LD_ERR;
          err_code_nxt = 2'd1;
        end else if (overrun) begin
          ld_state_nxt = LD_ERR;
          err_code_nxt = 2'd2;
        end else if (last_grant) begin
          ld_state_nxt = LD_DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q      <= '0;
      len_idx    <= '0;
      byte_idx   <= '0;
      asm_q      <= '0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      n_words    <= '0;
      words_rcvd <= '0;
      grants_q   <= '0;
    end else begin
      if (ld_state == LD_SYNC && ld_state_nxt == LD_LEN) begin
        len_idx    <= '0;
        byte_idx   <= '0;
        words_rcvd <= '0;
        grants_q   <= '0;
        wr_addr    <= '0;
      end
      if (ld_state == LD_LEN && byte_valid) begin
        len_q   <= len_full;
        len_idx <= len_idx + 2'd1;
      end
      if (ld_state == LD_LEN && ld_state_nxt == LD_DATA) n_words <= len_full[AddrWidth:0];
      // Bytes past the last word of the image are dropped.
      if (ld_state == LD_DATA && byte_valid && words_rcvd != n_words) begin
        asm_q    <= asm_nxt;
        byte_idx <= byte_idx + 6'd1;
      end
      if (gnt_fire) begin
        wr_req   <= 1'b0;
        wr_addr  <= wr_addr + AddrWidth'(1);
        grants_q <= grants_q + WordOne;
      end
      if (word_done && !overrun) begin
        wr_req     <= 1'b1;
        wr_data    <= asm_nxt;
        words_rcvd <= words_rcvd + WordOne;
      end
      if (ld_state_nxt == LD_ERR) wr_req <= 1'b0;
    end
  end

  assign mem.req    = wr_req;
  assign mem.addr   = wr_addr;
  assign mem.wdata  = wr_data;
  assign busy_o     = (ld_state == LD_LEN) || (ld_state == LD_DATA);
  assign done_o     = (ld_state == LD_DONE);
  assign err_o      = (ld_state == LD_ERR);
  assign err_code_o = err_code_q;

endmodule

// File: doc/uart_wide_mem_loader.md
Name: uart_wide_mem_loader

Overview:
Synthesizable UART boot loader for the simulation and bring-up path.
- Receives an 8N1 byte stream on the chip UART RX line, as sent by the host-side UART DPI transmitter.
- Packs the bytes into 512-bit words and writes them into the wide SPM through a req/gnt port.
- Replaces backdoor preloading of the wide SRAM. Byte i of the image lands in bits [8*(i%64)+7 : 8*(i%64)] of word i/64.

Parameters:
ClkFreq, 1_000_000_000, clk_i frequency in Hz
Baud, 20_000_000, UART baud rate; bit period Div = ClkFreq/Baud (default 50 cycles); Div >= 4 required
MemDepth, 16384, number of 512-bit words in the target memory
AddrWidth, $clog2(MemDepth), word address width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rx_i  in  1  UART serial input, idle high
mem_req_o  out  1  write request to wide SPM
mem_addr_o  out  AddrWidth  word address
mem_wdata_o  out  512  write data, byte 0 in bits [7:0]
mem_gnt_i  in  1  write accepted on a clock edge where mem_req_o=1
busy_o  out  1  loader between sync byte and done/error
done_o  out  1  image fully written (sticky)
err_o  out  1  error (sticky)
err_code_o  out  2  0 none, 1 framing, 2 overrun, 3 length

Behaviour:
- Reset values: all outputs 0; rx synchronizer flops reset to 1.
- rx_i passes through a 2-flop synchronizer (2-cycle latency). All timing below refers to the synchronized signal.
- Byte receiver FSM:
  - IDLE: a falling edge moves to START.
  - START: after Div/2 cycles, sample the line. Low goes to DATA; high is a false start and returns to IDLE with no error.
  - DATA: sample 8 bits, LSB first, every Div cycles.
  - STOP: sample Div cycles after bit 7. High pulses byte_valid for 1 cycle. Low raises a framing error.
  - In both STOP cases, return to IDLE.
- Loader FSM:
  - SYNC: non-0xA5 bytes are ignored. 0xA5 moves to LEN and sets busy_o.
  - LEN: 4 bytes form count N (little-endian, 64-byte words). N=0 goes directly to DONE. N>MemDepth sets error 3 (length). Otherwise go to DATA with word address 0.
  - DATA: bytes are shifted into a 512-bit assembly register at byte index 0..63. On the 64th byte the word moves to the write register and the index clears. mem_req_o asserts the next cycle.
  - The write register is held with addr/data stable until a grant edge. mem_req_o drops the cycle after the grant; address increments on the grant.
  - Receiving continues during the write (one word of buffering). If another word completes while the request is still ungranted, set error 2 (overrun).
  - After the N-th grant: done_o=1, busy_o=0 the next cycle.
- DONE and ERROR are sticky until reset. Further bytes are ignored.
- On any error: err_o=1, err_code_o latched (first error wins), mem_req_o dropped immediately, busy_o=0.
- Framing errors are reported only while busy_o=1. In SYNC they are silently discarded.
- Async reset mid-transfer: immediate return to SYNC, partial word discarded, memory contents left as is.

Test Plan:
- Send 0xA5, N=1 (01 00 00 00), bytes 0x00..0x3F with grant tied 1 -> one write at addr 0, wdata[7:0]=0x00, wdata[511:504]=0x3F; done_o=1 the cycle after the grant.
- Send 0x12, 0x34, then 0xA5, N=2, 128 bytes, grant delayed 30 cycles -> garbage bytes ignored; writes at addr 0 and 1, each request held stable until the grant.
- Send 0xA5, N=2, grant held 0 through both words -> err_o=1, err_code_o=2 after the 128th byte, mem_req_o=0.
- Send 0xA5 with N=16385 -> err_code_o=3, no memory request. Send 0xA5 with N=0 -> done_o=1, no request.
- Mid-image byte with stop bit driven 0 -> err_code_o=1. A 10-cycle low glitch on an idle line -> no byte and no error.
- Assert rst_ni low after 30 of 64 data bytes, then resend the full image with N=1 -> single write at addr 0 with the new data only.
